light_sequence_monitor: RTL



---
 rtl/light_mon_pkg.sv | 30 +++
 rtl/light_sequence_monitor_sat_counter.sv | 21 ++
 rtl/light_sequence_monitor.sv | 119 +++++++++++
 3 files changed

// File: rtl/light_mon_pkg.sv
// Shared phase encoding, lamp codes and code decoding for the traffic-light monitor.
package light_mon_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    GREEN  = 3'd1,
    YELLOW = 3'd2,
    RED    = 3'd3,
    FAULT  = 3'd4
  } phase_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  function automatic logic is_legal_code(input logic [2:0] code);
    return (code == LIGHT_RED) || (code == LIGHT_YELLOW) || (code == LIGHT_GREEN);
  endfunction

  // Illegal codes map to INIT; callers qualify with is_legal_code.
  function automatic phase_t code_to_phase(input logic [2:0] code);
    case (code)
      LIGHT_GREEN:  return GREEN;
      LIGHT_YELLOW: return YELLOW;
      LIGHT_RED:    return RED;
      default:      return INIT;
    endcase
  endfunction

endpackage

// File: rtl/light_sequence_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and a restart-at-one load.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (start)
      count <= CNT_W'(1);
    else if (en && (count != '1))
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/light_sequence_monitor.sv
// Passive checker of the traffic-light lamp bus: phase order, dwell times,
// pedestrian service, sticky fault flags and a legal-transition count.
module light_sequence_monitor
  import light_mon_pkg::*;
#(
  parameter int unsigned MIN_GREEN   = 4,
  parameter int unsigned MIN_YELLOW  = 2,
  parameter int unsigned MIN_RED     = 3,
  parameter int unsigned PED_TIMEOUT = 32,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       lights,
  input  logic             pedestrian_button,
  output logic             walk,
  output logic             ped_pending,
  output logic             err_illegal_code,
  output logic             err_bad_order,
  output logic             err_short_dwell,
  output logic             err_ped_timeout,
  output logic [CNT_W-1:0] phase_count
);

  phase_t           state;
  phase_t           code_ph;
  logic             legal, active, same, order_ok, adv, serve, short_dwell, timeout_hit;
  logic [CNT_W-1:0] dwell, wait_cnt, min_dwell;
  logic             dwell_start, dwell_en, wait_clr, wait_en;

  always_comb begin
    legal    = is_legal_code(lights);
    code_ph  = code_to_phase(lights);
    active   = (state != FAULT);
    same     = (code_ph == state);
    order_ok = ((state == GREEN)  && (code_ph == YELLOW)) ||
               ((state == YELLOW) && (code_ph == RED))    ||
               ((state == RED)    && (code_ph == GREEN));
    adv      = active && legal && order_ok;
    serve    = adv && (state == YELLOW) && (ped_pending || pedestrian_button);

    case (state)
      GREEN:   min_dwell = CNT_W'(MIN_GREEN);
      YELLOW:  min_dwell = CNT_W'(MIN_YELLOW);
      RED:     min_dwell = CNT_W'(MIN_RED);
      default: min_dwell = '0;
    endcase
    short_dwell = (dwell < min_dwell);

    dwell_start = !reset && (((state == INIT) && legal) || adv);
    dwell_en    = !reset && active && (state != INIT) && legal && same;

    // Wait counts only while a request is outstanding; serving it restarts at 0.
    wait_clr    = reset || serve || !ped_pending;
    wait_en     = ped_pending && active && !serve;
    timeout_hit = wait_en && (wait_cnt == CNT_W'(PED_TIMEOUT - 1));
  end

  sat_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk   (clk),
    .clr   (reset),
    .start (dwell_start),
    .en    (dwell_en),
    .count (dwell)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait (
    .clk   (clk),
    .clr   (wait_clr),
    .start (1'b0),
    .en    (wait_en),
    .count (wait_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= INIT;
      walk             <= 1'b0;
      ped_pending      <= 1'b0;
      err_illegal_code <= 1'b0;
      err_bad_order    <= 1'b0;
      err_short_dwell  <= 1'b0;
      err_ped_timeout  <= 1'b0;
      phase_count      <= '0;
    end else if (active) begin
      if (!legal) begin
        err_illegal_code <= 1'b1;
        state            <= FAULT;
        walk             <= 1'b0;
      end else if (state == INIT) begin
        state <= code_ph;
      end else if (!same) begin
        if (order_ok) begin
          state       <= code_ph;
          phase_count <= phase_count + CNT_W'(1);
          if (short_dwell)
            err_short_dwell <= 1'b1;
          if (serve)
            walk <= 1'b1;
          else if (state == RED)
            walk <= 1'b0;
        end else begin
          err_bad_order <= 1'b1;
          state         <= FAULT;
          walk          <= 1'b0;
        end
      end

      if (serve)
        ped_pending <= 1'b0;
      else if (pedestrian_button && (state != RED))
        ped_pending <= 1'b1;

      if (timeout_hit)
        err_ped_timeout <= 1'b1;
    end
  end

endmodule
